// File: rtl/uart_pkg.sv
// Shared types, stop-bit encodings and the parity helper for the buffered UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } tx_state_e;

   localparam logic [1:0] STOP_1   = 2'd0;
   localparam logic [1:0] STOP_1P5 = 2'd1;
   localparam logic [1:0] STOP_2   = 2'd2;

   localparam int PARITY_MAX_BITS = 16;

   // Only the low `length` bits take part; stick mode ignores the data entirely.
   function automatic logic parity_calc(input logic [PARITY_MAX_BITS-1:0] data,
                                        input logic [3:0]                 length,
                                        input logic                       even,
                                        input logic                       stick);
      logic ones;
      ones = 1'b0;
      for (int i = 0; i < PARITY_MAX_BITS; i++) begin
         if (i < int'(length)) ones ^= data[i];
      end
      if (stick) return ~even;
      return even ? ones : ~ones;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and extra-MSB pointer wrap.
module uart_sync_fifo #(
   parameter int DATA_WIDTH = 9,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH),
   localparam int LW        = AW + 1
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  write_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  read_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [LW-1:0]         level_o,
   output logic                  overflow_o
);

   localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
   localparam logic [AW:0] LEVEL_MAX = (AW + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_d;
   logic                  push, pop;

   assign push = write_i & ~full_o;
   assign pop  = read_i & ~empty_o;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      level_d = wr_ptr_d - rd_ptr_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_o    <= '0;
         full_o     <= 1'b0;
         empty_o    <= 1'b1;
         overflow_o <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_o    <= level_d;
         full_o     <= (level_d == LEVEL_MAX);
         empty_o    <= (level_d == '0);
         overflow_o <= write_i & full_o;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clock_i) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= data_i;
   end

   assign data_o = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end, per-frame latched configuration, break generation.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = 9,
   parameter int FIFO_DEPTH    = 16,
   parameter int DIVIDER_WIDTH = 16,
   parameter int LEVEL_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     write_i,
   input  logic [DATA_WIDTH-1:0]    data_i,
   input  logic [3:0]               data_bits_i,
   input  logic                     parity_bit_i,
   input  logic                     parity_even_i,
   input  logic                     parity_stick_i,
   input  logic [1:0]               stop_bits_i,
   input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
   input  logic                     break_i,
   output logic                     serial_o,
   output logic                     busy_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [LEVEL_WIDTH-1:0]   level_o,
   output logic                     overflow_o
);

   localparam int CW = DIVIDER_WIDTH + 1;
   localparam logic [3:0]    MIN_BITS = 4'd5;
   localparam logic [3:0]    MAX_BITS = 4'(DATA_WIDTH);
   localparam logic [3:0]    BIT_ONE  = 4'd1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   tx_state_e               state_q, state_d;
   logic [CW-1:0]           div_cnt_q, div_cnt_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [3:0]              len_q, len_d, len_new;
   logic                    par_en_q, par_en_d;
   logic                    par_val_q, par_val_d, par_val_new;
   logic [DIVIDER_WIDTH-1:0] div_q, div_d;
   logic [CW-1:0]           stop_last_q, stop_last_d, stop_last_new;
   logic [CW-1:0]           div_ext, half_bit;
   logic                    line_q, line_d;
   logic                    pop, idle_decide, bit_done;
   logic [DATA_WIDTH-1:0]   fifo_data;
   logic                    fifo_empty;

   uart_sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .write_i   (write_i),
      .data_i    (data_i),
      .read_i    (pop),
      .data_o    (fifo_data),
      .full_o    (full_o),
      .empty_o   (fifo_empty),
      .level_o   (level_o),
      .overflow_o(overflow_o)
   );

   // Frame parameters as they would be captured if a pop happened this cycle.
   always_comb begin
      len_new = data_bits_i;
      if (data_bits_i < MIN_BITS) len_new = MIN_BITS;
      else if (data_bits_i > MAX_BITS) len_new = MAX_BITS;

      par_val_new = parity_calc(16'(fifo_data), len_new, parity_even_i, parity_stick_i);

      div_ext  = {1'b0, clock_divider_i};
      half_bit = (div_ext + CNT_ONE) >> 1;
      if (half_bit == '0) half_bit = CNT_ONE;

      case (stop_bits_i)
         STOP_1:   stop_last_new = div_ext;
         STOP_1P5: stop_last_new = div_ext + half_bit;
         default:  stop_last_new = (div_ext << 1) + CNT_ONE;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      len_d       = len_q;
      par_en_d    = par_en_q;
      par_val_d   = par_val_q;
      div_d       = div_q;
      stop_last_d = stop_last_q;
      pop         = 1'b0;
      idle_decide = 1'b0;
      line_d      = 1'b1;

      // The whole stop interval is timed by one counter run, so 1.5 bits needs no special state.
      bit_done = (div_cnt_q == ((state_q == ST_STOP) ? stop_last_q : {1'b0, div_q}));

      case (state_q)
         ST_IDLE: idle_decide = 1'b1;
         ST_START: begin
            if (bit_done) begin
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end else begin
               div_cnt_d = div_cnt_q + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               div_cnt_d = '0;
               shift_d   = shift_q >> 1;
               if (bit_cnt_q == len_q - BIT_ONE) state_d = par_en_q ? ST_PARITY : ST_STOP;
               else bit_cnt_d = bit_cnt_q + BIT_ONE;
            end else begin
               div_cnt_d = div_cnt_q + CNT_ONE;
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               div_cnt_d = '0;
               state_d   = ST_STOP;
            end else begin
               div_cnt_d = div_cnt_q + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (bit_done) idle_decide = 1'b1;
            else div_cnt_d = div_cnt_q + CNT_ONE;
         end
         ST_BREAK: if (!break_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Taken on the edge that ends a stop bit as well, so queued frames go out back to back.
      if (idle_decide) begin
         if (break_i) begin
            state_d = ST_BREAK;
         end else if (!fifo_empty) begin
            pop         = 1'b1;
            state_d     = ST_START;
            div_cnt_d   = '0;
            shift_d     = fifo_data;
            len_d       = len_new;
            par_en_d    = parity_bit_i;
            par_val_d   = par_val_new;
            div_d       = clock_divider_i;
            stop_last_d = stop_last_new;
         end else begin
            state_d = ST_IDLE;
         end
      end

      case (state_d)
         ST_START:  line_d = 1'b0;
         ST_DATA:   line_d = shift_d[0];
         ST_PARITY: line_d = par_val_q;
         ST_BREAK:  line_d = 1'b0;
         default:   line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         len_q       <= MIN_BITS;
         par_en_q    <= 1'b0;
         par_val_q   <= 1'b0;
         div_q       <= '0;
         stop_last_q <= '0;
         line_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         len_q       <= len_d;
         par_en_q    <= par_en_d;
         par_val_q   <= par_val_d;
         div_q       <= div_d;
         stop_last_q <= stop_last_d;
         line_q      <= line_d;
      end
   end

   assign serial_o = line_q;
   assign busy_o   = (state_q != ST_IDLE);
   assign empty_o  = fifo_empty;

endmodule
